instruction_fetch_unit: RTL and testbench

Parametrised fetch stage for the MIPS/DLX pipeline. It owns the program counter and drives a synchronous-read (1-cycle latency) instruction memory. It presents an instruction, its PC and PC+INC to the IF/ID boundary with a valid flag. Over a plain fetch stage it adds:
- parametrised address/data widths and reset vector;
- pipeline stall with an internal hold register;
- redirect (jump/branch) with in-flight squash;
- a valid qualifier.

---
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous-read instruction memory and
// presents {instruction, PC, PC+INC, valid} to the IF/ID boundary. It supports stall (with a
// hold register) and redirect (with squash of the in-flight fetch).
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_INC     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruc,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] PC_plus_1
);

  localparam logic [ADDR_WIDTH-1:0] PcInc = ADDR_WIDTH'(PC_INC);

  // Architectural state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_hold_reg;
  logic                  r_holding;

  // Next-state values
  logic [ADDR_WIDTH-1:0] w_fetch_pc_d;
  logic [ADDR_WIDTH-1:0] w_resp_pc_d;
  logic                  w_resp_valid_d;
  logic [DATA_WIDTH-1:0] w_hold_reg_d;
  logic                  w_holding_d;

  // Next-state selection, priority redirect > stall > advance.
  always_comb begin
    w_fetch_pc_d   = r_fetch_pc;
    w_resp_pc_d    = r_resp_pc;
    w_resp_valid_d = r_resp_valid;
    w_hold_reg_d   = r_hold_reg;
    w_holding_d    = r_holding;
    if (redirect) begin
      // Squash whatever the memory is answering; resp_pc is left as-is.
      w_fetch_pc_d   = redirect_addr;
      w_resp_valid_d = 1'b0;
      w_holding_d    = 1'b0;
    end else if (stall) begin
      // Capture the current word once; memory keeps reading fetch_pc, so on release its
      // output already belongs to the next instruction.
      if (!r_holding) begin
        w_hold_reg_d = imem_rdata;
        w_holding_d  = 1'b1;
      end
    end else begin
      w_resp_pc_d    = r_fetch_pc;
      w_resp_valid_d = 1'b1;
      w_holding_d    = 1'b0;
      w_fetch_pc_d   = r_fetch_pc + PcInc;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_hold_reg   <= '0;
      r_holding    <= 1'b0;
    end else begin
      r_fetch_pc   <= w_fetch_pc_d;
      r_resp_pc    <= w_resp_pc_d;
      r_resp_valid <= w_resp_valid_d;
      r_hold_reg   <= w_hold_reg_d;
      r_holding    <= w_holding_d;
    end
  end

  // Output mux: invalid slots read as NOP; a held word overrides the live memory data.
  always_comb begin
    imem_addr   = r_fetch_pc;
    instr_valid = r_resp_valid;
    pc_out      = r_resp_pc;
    PC_plus_1   = r_resp_pc + PcInc;
    if (!r_resp_valid) begin
      instruc = '0;
    end else if (r_holding) begin
      instruc = r_hold_reg;
    end else begin
      instruc = imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a table of per-edge stimulus and expected outputs
// feeding a scoreboard queue, plus hand-written stall/async-reset sequences and a
// 32-bit byte-addressed parameter variant.
module tb_instruction_fetch_unit;

  typedef struct {
    logic       stall;
    logic       redirect;
    logic [9:0] raddr;
    logic       exp_valid;
    logic [9:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  pc;
    logic [9:0]  pcp1;
  } exp_t;

  localparam logic [31:0] ResetB = 32'hBFC0_0000;

  logic clock = 1'b0;
  logic reset_n;
  logic stall, redirect;
  logic [9:0] redirect_addr;

  // Default instance (10-bit word addressing)
  logic [9:0]  imem_addr_a, pc_out_a, pcp1_a;
  logic [31:0] rdata_a, instruc_a;
  logic        valid_a;

  // Variant instance (32-bit byte addressing)
  logic [31:0] imem_addr_b, pc_out_b, pcp1_b, rdata_b, instruc_b;
  logic        valid_b;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[20];
  exp_t sb[$];

  always #5 clock = ~clock;

  instruction_fetch_unit u_dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .imem_addr    (imem_addr_a),
    .imem_rdata   (rdata_a),
    .instr_valid  (valid_a),
    .instruc      (instruc_a),
    .pc_out       (pc_out_a),
    .PC_plus_1    (pcp1_a)
  );

  instruction_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (ResetB),
    .PC_INC    (4)
  ) u_dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (1'b0),
    .redirect     (1'b0),
    .redirect_addr(32'h0),
    .imem_addr    (imem_addr_b),
    .imem_rdata   (rdata_b),
    .instr_valid  (valid_b),
    .instruc      (instruc_b),
    .pc_out       (pc_out_b),
    .PC_plus_1    (pcp1_b)
  );

  // Synchronous-read memories: word = 0x1000_0000 + address.
  always @(posedge clock) begin
    rdata_a <= 32'h1000_0000 + {22'h0, imem_addr_a};
    rdata_b <= 32'h1000_0000 + imem_addr_b;
  end

  function automatic logic [31:0] mem_a(input logic [9:0] a);
    return 32'h1000_0000 + {22'h0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic s, input logic r, input logic [9:0] ra,
                      input logic ev, input logic [9:0] ep);
    vecs[i].stall     = s;
    vecs[i].redirect  = r;
    vecs[i].raddr     = ra;
    vecs[i].exp_valid = ev;
    vecs[i].exp_pc    = ep;
  endtask

  initial begin
    exp_t e;
    // stall, redirect, target, expected valid, expected pc_out after the edge
    setv(0,  0, 0, 10'h000, 1, 10'h000);
    setv(1,  0, 0, 10'h000, 1, 10'h001);
    setv(2,  0, 0, 10'h000, 1, 10'h002);
    setv(3,  1, 0, 10'h000, 1, 10'h002);
    setv(4,  1, 0, 10'h000, 1, 10'h002);
    setv(5,  1, 0, 10'h000, 1, 10'h002);
    setv(6,  0, 0, 10'h000, 1, 10'h003);
    setv(7,  0, 0, 10'h000, 1, 10'h004);
    setv(8,  0, 0, 10'h000, 1, 10'h005);
    setv(9,  0, 1, 10'h100, 0, 10'h005);  // bubble; pc_out keeps old value
    setv(10, 0, 0, 10'h000, 1, 10'h100);
    setv(11, 0, 0, 10'h000, 1, 10'h101);
    setv(12, 1, 1, 10'h020, 0, 10'h101);  // redirect beats stall
    setv(13, 1, 0, 10'h000, 0, 10'h101);  // stall during bubble stays invalid
    setv(14, 0, 0, 10'h000, 1, 10'h020);
    setv(15, 0, 1, 10'h3FE, 0, 10'h020);
    setv(16, 0, 0, 10'h000, 1, 10'h3FE);
    setv(17, 0, 0, 10'h000, 1, 10'h3FF);
    setv(18, 0, 0, 10'h000, 1, 10'h000);
    setv(19, 0, 0, 10'h000, 1, 10'h001);

    reset_n       = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    repeat (2) @(negedge clock);

    chk("rst_valid_a", {31'h0, valid_a}, 32'h0);
    chk("rst_instr_a", instruc_a, 32'h0);
    chk("rst_pc_a", {22'h0, pc_out_a}, 32'h0);
    chk("rst_pcp1_a", {22'h0, pcp1_a}, 32'h1);
    chk("rst_imem_a", {22'h0, imem_addr_a}, 32'h0);
    chk("rst_valid_b", {31'h0, valid_b}, 32'h0);
    chk("rst_pc_b", pc_out_b, ResetB);
    chk("rst_pcp1_b", pcp1_b, ResetB + 32'd4);

    reset_n = 1'b1;
    #1;
    chk("pre_edge_valid_a", {31'h0, valid_a}, 32'h0);
    chk("pre_edge_instr_a", instruc_a, 32'h0);

    for (int i = 0; i < 20; i++) begin
      stall         = vecs[i].stall;
      redirect      = vecs[i].redirect;
      redirect_addr = vecs[i].raddr;
      e.valid = vecs[i].exp_valid;
      e.pc    = vecs[i].exp_pc;
      e.pcp1  = vecs[i].exp_pc + 10'd1;
      e.instr = vecs[i].exp_valid ? mem_a(vecs[i].exp_pc) : 32'h0;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", i), {31'h0, valid_a}, {31'h0, e.valid});
        chk($sformatf("v%0d_instr", i), instruc_a, e.instr);
        chk($sformatf("v%0d_pc", i), {22'h0, pc_out_a}, {22'h0, e.pc});
        chk($sformatf("v%0d_pcp1", i), {22'h0, pcp1_a}, {22'h0, e.pcp1});
      end
      if (i < 4) begin
        chk($sformatf("b%0d_valid", i), {31'h0, valid_b}, 32'h1);
        chk($sformatf("b%0d_pc", i), pc_out_b, ResetB + 32'(4 * i));
        chk($sformatf("b%0d_instr", i), instruc_b, 32'h1000_0000 + ResetB + 32'(4 * i));
      end
      @(negedge clock);
    end
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;

    // Stall two edges so the hold register is in use, then drop reset between edges.
    stall = 1'b1;
    @(posedge clock);
    #1;
    chk("hold1_instr", instruc_a, mem_a(10'h001));
    @(negedge clock);
    @(posedge clock);
    #2;
    chk("hold2_instr", instruc_a, mem_a(10'h001));
    chk("hold2_pc", {22'h0, pc_out_a}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, valid_a}, 32'h0);
    chk("async_rst_imem", {22'h0, imem_addr_a}, 32'h0);
    chk("async_rst_instr", instruc_a, 32'h0);
    chk("async_rst_pc", {22'h0, pc_out_a}, 32'h0);
    chk("async_rst_pc_b", imem_addr_b, ResetB);

    @(negedge clock);
    stall   = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_valid", {31'h0, valid_a}, 32'h1);
    chk("post_rst_pc", {22'h0, pc_out_a}, 32'h0);
    chk("post_rst_instr", instruc_a, mem_a(10'h000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
